// File: rtl/cart_sram_backup.sv
// Backup-SRAM controller: shares the cartridge SRAM between mapper CPU access
// and a sector engine that loads/saves the image over the sd_* block interface.
module cart_sram_backup #(
    parameter int unsigned SRAM_AW = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SRAM_AW-1:0]  cpu_addr,
    input  logic [7:0]          cpu_din,
    input  logic                cpu_we,
    input  logic                cpu_oe,
    output logic [7:0]          cpu_dout,
    output logic [SRAM_AW-1:0]  ram_addr,
    output logic [7:0]          ram_din,
    output logic                ram_we,
    input  logic [7:0]          ram_dout,
    input  logic                load_req,
    input  logic                save_req,
    output logic [31:0]         sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    input  logic [8:0]          sd_buff_addr,
    input  logic [7:0]          sd_buff_dout,
    output logic [7:0]          sd_buff_din,
    input  logic                sd_buff_wr,
    output logic                busy,
    output logic                dirty
);

    localparam int unsigned SEC_W = SRAM_AW - 9;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_NEXT} state_t;
    typedef enum logic {OP_LOAD, OP_SAVE} op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               dirty_q, dirty_d;
    logic               busy_q, busy_d;
    logic               sd_rd_q, sd_rd_d;
    logic               sd_wr_q, sd_wr_d;

    // Read enable has no effect: the SRAM read path is always live.
    logic unused_cpu_oe;
    assign unused_cpu_oe = cpu_oe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            sec_q   <= '0;
            dirty_q <= 1'b0;
            busy_q  <= 1'b0;
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sec_q   <= sec_d;
            dirty_q <= dirty_d;
            busy_q  <= busy_d;
            sd_rd_q <= sd_rd_d;
            sd_wr_q <= sd_wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sec_d   = sec_q;
        dirty_d = dirty_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_we) dirty_d = 1'b1;
                // A CPU write in the same cycle counts toward the save decision.
                if (load_req) begin
                    state_d = S_REQ;
                    op_d    = OP_LOAD;
                    sec_d   = '0;
                end else if (save_req && (dirty_q || cpu_we)) begin
                    state_d = S_REQ;
                    op_d    = OP_SAVE;
                    sec_d   = '0;
                end
            end
            S_REQ:  if (sd_ack)  state_d = S_XFER;
            S_XFER: if (!sd_ack) state_d = S_NEXT;
            S_NEXT: begin
                if (&sec_q) begin
                    state_d = S_IDLE;
                    sec_d   = '0;
                    dirty_d = 1'b0;
                end else begin
                    state_d = S_REQ;
                    sec_d   = sec_q + SEC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        sd_rd_d = (state_d == S_REQ) && (op_d == OP_LOAD);
        sd_wr_d = (state_d == S_REQ) && (op_d == OP_SAVE);
    end

    // SRAM ownership: CPU in IDLE, sector engine otherwise.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_we;
        cpu_dout = ram_dout;
        if (state_q != S_IDLE) begin
            ram_addr = {sec_q, sd_buff_addr};
            ram_din  = sd_buff_dout;
            ram_we   = (op_q == OP_LOAD) && sd_buff_wr && sd_ack;
            cpu_dout = 8'hFF;
        end
    end

    assign sd_buff_din = ram_dout;
    assign sd_lba      = 32'(sec_q);
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign busy        = busy_q;
    assign dirty       = dirty_q;

endmodule

// File: tb/tb_cart_sram_backup.sv
// Scoreboard bench for cart_sram_backup: SRAM and host models, queued expectations
// for CPU reads and sector requests, checked by a negedge monitor.
module tb_cart_sram_backup;

    localparam int unsigned AW   = 15;
    localparam int unsigned NSEC = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_we, cpu_oe;
    logic [7:0]    cpu_dout;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic          load_req, save_req;
    logic [31:0]   sd_lba;
    logic          sd_rd, sd_wr, sd_ack;
    logic [8:0]    sd_buff_addr;
    logic [7:0]    sd_buff_dout, sd_buff_din;
    logic          sd_buff_wr;
    logic          busy, dirty;

    cart_sram_backup #(.SRAM_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
        .cpu_dout(cpu_dout),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .load_req(load_req), .save_req(save_req),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .busy(busy), .dirty(dirty)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 13) ^ 8'(a >> 9);
    endfunction

    function automatic logic [7:0] exp_save(input int a);
        return (a == 32'h123) ? 8'h5A : init_val(a);
    endfunction

    // SRAM model: synchronous write, read data one clock after address
    logic [7:0] mem [0:(1<<AW)-1];
    logic       preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    typedef struct packed {
        logic        rd;
        logic [31:0] lba;
    } req_t;

    req_t       req_q[$];
    logic [7:0] rd_q[$];
    logic       req_prev = 1'b0;
    logic       rd_pend  = 1'b0;

    // Monitor: CPU read data and every new sector request
    always @(negedge clk) begin
        req_t       r;
        logic [7:0] e;
        if (rd_pend) begin
            if (rd_q.size() == 0) check("cpu_read_unexpected", 32'(cpu_dout), 32'hFFFF_FFFF);
            else begin
                e = rd_q.pop_front();
                check("cpu_dout", 32'(cpu_dout), 32'(e));
            end
        end
        rd_pend = cpu_oe;
        if ((sd_rd || sd_wr) && !req_prev) begin
            if (req_q.size() == 0) check("sd_req_unexpected", {30'd0, sd_rd, sd_wr}, 32'd0);
            else begin
                r = req_q.pop_front();
                check("sd_rd", 32'(sd_rd), 32'(r.rd));
                check("sd_wr", 32'(sd_wr), 32'(!r.rd));
                check("sd_lba", sd_lba, r.lba);
            end
        end
        req_prev = sd_rd || sd_wr;
    end

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] exp);
        @(posedge clk); #1;
        cpu_addr = a; cpu_oe = 1'b1;
        rd_q.push_back(exp);
        @(posedge clk); #1;
        cpu_oe = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_reqs(input logic rd, input int first, input int last);
        for (int s = first; s <= last; s++) req_q.push_back('{rd: rd, lba: 32'(s)});
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sd_rd || sd_wr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("sd_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic host_save(input int lba);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        @(posedge clk); #1;
        sd_ack = 1'b1;
        for (int i = 0; i <= 512; i++) begin
            @(posedge clk); #1;
            if (i > 0) check("save_byte", 32'(sd_buff_din), 32'(exp_save(lba * 512 + i - 1)));
            if (i < 512) sd_buff_addr = 9'(i);
        end
        sd_ack = 1'b0;
    endtask

    task automatic host_load(input int lba);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        @(posedge clk); #1;
        sd_ack = 1'b1;
        for (int i = 0; i < 512; i++) begin
            @(posedge clk); #1;
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'(lba ^ i);
            sd_buff_wr   = 1'b1;
        end
        @(posedge clk); #1;
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
    endtask

    initial begin
        bit ok;
        int errs;
        reset = 1'b1;
        cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0; cpu_oe = 1'b0;
        load_req = 1'b0; save_req = 1'b0; sd_ack = 1'b0;
        sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dirty", 32'(dirty), 32'd0);
        check("rst_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_sd_wr", 32'(sd_wr), 32'd0);
        check("rst_sd_lba", sd_lba, 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        reset = 1'b0;

        // Save while clean is ignored
        @(posedge clk); #1; save_req = 1'b1;
        @(posedge clk); #1; save_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("clean_save_busy", 32'(busy), 32'd0);

        // CPU write and read-back
        cpu_write(15'h0123, 8'h5A);
        check("dirty_after_write", 32'(dirty), 32'd1);
        cpu_read(15'h0123, 8'h5A);
        cpu_read(15'h0456, init_val(32'h456));

        // Full save of 64 sectors
        push_reqs(1'b0, 0, NSEC - 1);
        @(posedge clk); #1; save_req = 1'b1;
        @(posedge clk); #1; save_req = 1'b0;
        check("save_busy", 32'(busy), 32'd1);
        for (int s = 0; s < NSEC; s++) host_save(s);
        repeat (3) @(posedge clk);
        #1;
        check("save_done_busy", 32'(busy), 32'd0);
        check("save_done_dirty", 32'(dirty), 32'd0);

        // Full load with CPU access attempted mid-load
        push_reqs(1'b1, 0, NSEC - 1);
        @(posedge clk); #1; load_req = 1'b1;
        @(posedge clk); #1; load_req = 1'b0;
        host_load(0);
        cpu_write(15'h0010, 8'hEE);
        cpu_read(15'h0020, 8'hFF);
        for (int s = 1; s < NSEC; s++) host_load(s);
        repeat (3) @(posedge clk);
        #1;
        check("load_done_busy", 32'(busy), 32'd0);
        check("load_done_dirty", 32'(dirty), 32'd0);
        errs = 0;
        for (int a = 0; a < (1 << AW); a++)
            if (mem[a] !== 8'((a >> 9) ^ (a & 511))) errs++;
        check("load_image_errs", 32'(errs), 32'd0);
        cpu_read(15'h0010, 8'h10);
        cpu_read(15'h7FFF, 8'hC0);
        cpu_read(15'h0A07, 8'h02);

        // Simultaneous requests: load wins; then reset mid-XFER of sector 5
        cpu_write(15'h0200, 8'h33);
        check("dirty_before_both", 32'(dirty), 32'd1);
        push_reqs(1'b1, 0, 5);
        @(posedge clk); #1; load_req = 1'b1; save_req = 1'b1;
        @(posedge clk); #1; load_req = 1'b0; save_req = 1'b0;
        for (int s = 0; s < 5; s++) host_load(s);
        wait_req(ok);
        @(posedge clk); #1;
        sd_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("xfer_busy", 32'(busy), 32'd1);
        check("xfer_lba", sd_lba, 32'd5);
        reset = 1'b1;
        #1;
        check("abort_sd_rd", 32'(sd_rd), 32'd0);
        check("abort_sd_wr", 32'(sd_wr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dirty", 32'(dirty), 32'd0);
        @(posedge clk); #1;
        sd_ack = 1'b0;
        reset  = 1'b0;

        // Restart after abort begins at lba 0
        push_reqs(1'b1, 0, 0);
        @(posedge clk); #1; load_req = 1'b1;
        @(posedge clk); #1; load_req = 1'b0;
        wait_req(ok);
        check("restart_lba", sd_lba, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
